// File: rtl/ifetch_pkg.sv
// Shared types and constants for the instruction-fetch queue slice.
package ifetch_pkg;

   localparam logic [31:0] RESET_VECTOR = 32'hBFC0_0000;
   localparam logic [4:0]  EXC_ADEL     = 5'h04;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
      logic        adel;
   } q_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO with clear; push to a full FIFO
// is accepted only together with a pop.
module sync_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic                       clear,
   input  logic [WIDTH-1:0]           din,
   output logic [WIDTH-1:0]           dout,
   output logic                       full,
   output logic                       empty,
   output logic [$clog2(DEPTH+1)-1:0] count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign empty   = (count == '0);
   assign full    = (count == CW'(DEPTH));
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign dout    = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   end

endmodule

// File: rtl/ifetch_queue.sv
// Fetch-request issue and instruction buffer between the PC stage and decode;
// pairs in-order imem responses with their PCs and drops stale ones after a flush.
module ifetch_queue
   import ifetch_pkg::*;
#(
   parameter int DEPTH   = 4,
   parameter int MAX_OUT = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_in,
   input  logic        flush,
   output logic        fetch_stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        id_valid,
   output logic [31:0] id_pc,
   output logic [31:0] id_inst,
   output logic        id_adel,
   input  logic        id_ready
);
   localparam int QCW = $clog2(DEPTH+1);
   localparam int OCW = $clog2(MAX_OUT+1);

   logic [QCW-1:0] q_cnt;
   logic [OCW-1:0] out_cnt;
   logic [OCW-1:0] drop_cnt;
   logic           q_full, q_empty, q_push, q_pop;
   logic           pend_full, pend_empty;
   logic [31:0]    pend_pc;
   q_entry_t       q_din, q_dout;
   logic           can_issue, aligned, issue_mem, issue_adel, resp_keep;
   int unsigned    occ, inflight;

   always_comb begin
      occ        = 32'(q_cnt) + 32'(out_cnt);
      inflight   = 32'(out_cnt) + 32'(drop_cnt);
      aligned    = (pc_in[1:0] == 2'b00);
      can_issue  = !rst && !flush && !q_full && !pend_full &&
                   (occ < 32'(DEPTH)) && (inflight < 32'(MAX_OUT));
      imem_req   = can_issue && aligned;
      issue_mem  = imem_req && imem_gnt;
      // A misaligned PC must not overtake fetches still in flight.
      issue_adel = can_issue && !aligned && pend_empty;
      fetch_stall = !(issue_mem || issue_adel);
      resp_keep  = imem_rvalid && !flush && (drop_cnt == '0) && !pend_empty;
      q_push     = resp_keep || issue_adel;
      q_din      = '{pc: pend_pc, inst: imem_rdata, adel: 1'b0};
      if (issue_adel) q_din = '{pc: pc_in, inst: 32'h0, adel: 1'b1};
   end

   assign imem_addr = pc_in;
   assign id_valid  = !rst && !q_empty;
   assign q_pop     = id_valid && id_ready && !flush;
   assign id_pc     = q_dout.pc;
   assign id_inst   = q_dout.inst;
   assign id_adel   = q_dout.adel;

   // out_cnt is the pending-PC occupancy: one entry per granted, unanswered request.
   sync_fifo #(.WIDTH(32), .DEPTH(MAX_OUT)) u_pend (
      .clk(clk), .rst(rst), .push(issue_mem), .pop(resp_keep), .clear(flush),
      .din(pc_in), .dout(pend_pc), .full(pend_full), .empty(pend_empty),
      .count(out_cnt)
   );

   sync_fifo #(.WIDTH($bits(q_entry_t)), .DEPTH(DEPTH)) u_queue (
      .clk(clk), .rst(rst), .push(q_push), .pop(q_pop), .clear(flush),
      .din(q_din), .dout(q_dout), .full(q_full), .empty(q_empty),
      .count(q_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         drop_cnt <= '0;
      end else if (flush) begin
         drop_cnt <= drop_cnt + out_cnt -
                     OCW'(imem_rvalid && ((drop_cnt != '0) || (out_cnt != '0)));
      end else if (imem_rvalid && (drop_cnt != '0)) begin
         drop_cnt <= drop_cnt - 1'b1;
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// Randomized bench for ifetch_queue against a transaction-level queue model
// with an in-order, variable-latency instruction memory.
module tb_ifetch_queue;
   import ifetch_pkg::*;

   localparam int DEPTH   = 4;
   localparam int MAX_OUT = 2;

   logic        clk, rst, flush, fetch_stall, imem_req, imem_gnt, imem_rvalid;
   logic        id_valid, id_adel, id_ready;
   logic [31:0] pc_in, imem_addr, imem_rdata, id_pc, id_inst;

   ifetch_queue #(.DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
      .clk(clk), .rst(rst), .pc_in(pc_in), .flush(flush),
      .fetch_stall(fetch_stall), .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_gnt(imem_gnt), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .id_valid(id_valid), .id_pc(id_pc), .id_inst(id_inst), .id_adel(id_adel),
      .id_ready(id_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [31:0] addr;
   } rsp_t;

   int          n_vec = 0;
   int          n_err = 0;
   q_entry_t    m_q[$];
   logic [31:0] m_pend[$];
   int          m_drop;
   rsp_t        rsp_q[$];
   int          last_due, cyc;
   logic [31:0] pc;
   int          p_gnt, lat_lo, lat_hi, p_ready, p_flush, p_mis;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'hA5C3_0F1E;
   endfunction

   task automatic do_reset();
      rst = 1'b1; flush = 1'b0; imem_gnt = 1'b0; imem_rvalid = 1'b0;
      imem_rdata = 32'h0; id_ready = 1'b0; pc_in = RESET_VECTOR;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_imem_req", 32'(imem_req), 32'd0);
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_fetch_stall", 32'(fetch_stall), 32'd1);
      rst = 1'b0;
      m_q.delete(); m_pend.delete(); m_drop = 0;
      rsp_q.delete(); last_due = -1;
      pc = RESET_VECTOR;
   endtask

   task automatic run(input int ncyc);
      logic        can, e_req, e_mem, e_adel, e_valid;
      logic [31:0] a, tgt;
      int          owed, due;
      for (int i = 0; i < ncyc; i++) begin
         pc_in    = pc;
         flush    = ($urandom_range(99) < p_flush);
         imem_gnt = ($urandom_range(99) < p_gnt);
         id_ready = ($urandom_range(99) < p_ready);
         if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mem_word(rsp_q[0].addr);
         end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
         end
         can     = !flush && (m_q.size() + m_pend.size() < DEPTH) &&
                   (m_pend.size() + m_drop < MAX_OUT);
         e_req   = can && (pc[1:0] == 2'b00);
         e_mem   = e_req && imem_gnt;
         e_adel  = can && (pc[1:0] != 2'b00) && (m_pend.size() == 0);
         e_valid = (m_q.size() > 0);
         #1;
         chk("imem_req", 32'(imem_req), 32'(e_req));
         chk("imem_addr", imem_addr, pc);
         chk("fetch_stall", 32'(fetch_stall), 32'(!(e_mem || e_adel)));
         chk("id_valid", 32'(id_valid), 32'(e_valid));
         if (e_valid) begin
            chk("id_pc", id_pc, m_q[0].pc);
            chk("id_inst", id_inst, m_q[0].inst);
            chk("id_adel", 32'(id_adel), 32'(m_q[0].adel));
         end
         @(posedge clk);
         if (imem_rvalid) void'(rsp_q.pop_front());
         if (flush) begin
            // every response still owed by memory becomes stale, minus this cycle's
            owed = m_drop + m_pend.size() - (imem_rvalid ? 1 : 0);
            m_drop = owed;
            m_pend.delete();
            m_q.delete();
         end else begin
            if (e_valid && id_ready) void'(m_q.pop_front());
            if (imem_rvalid) begin
               if (m_drop > 0) m_drop--;
               else if (m_pend.size() > 0) begin
                  a = m_pend.pop_front();
                  m_q.push_back('{pc: a, inst: mem_word(a), adel: 1'b0});
               end
            end
            if (e_mem)  m_pend.push_back(pc);
            if (e_adel) m_q.push_back('{pc: pc, inst: 32'h0, adel: 1'b1});
            chk("q_no_overflow", 32'(m_q.size() <= DEPTH), 32'd1);
         end
         if (e_mem) begin
            due = cyc + int'($urandom_range(lat_hi, lat_lo));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            rsp_q.push_back('{due: due, addr: pc});
         end
         if (flush) begin
            tgt = ($urandom_range(99) < 20) ? 32'h8000_0180 : ($urandom & 32'hFFFF_FFFC);
            if ($urandom_range(99) < p_mis) tgt = tgt | 32'h2;
            pc = tgt;
         end else if (e_mem || e_adel) begin
            if (pc[1] || $urandom_range(99) < p_mis) pc = pc + 32'd2;
            else pc = pc + 32'd4;
         end
         cyc++;
         @(negedge clk);
      end
   endtask

   task automatic knobs(input int g, input int llo, input int lhi, input int r,
                        input int f, input int m);
      p_gnt = g; lat_lo = llo; lat_hi = lhi; p_ready = r; p_flush = f; p_mis = m;
   endtask

   initial begin
      cyc = 0;
      do_reset();
      knobs(100, 1, 1, 100, 0, 0);   run(30);    // streaming, one entry per cycle
      knobs(100, 1, 1, 0, 0, 0);     run(15);    // queue fills to DEPTH and stalls
      knobs(100, 1, 1, 15, 0, 0);    run(40);    // single pops re-open single issues
      do_reset();
      knobs(100, 5, 5, 100, 0, 0);   run(40);    // long latency saturates MAX_OUT
      knobs(100, 1, 1, 100, 0, 30);  run(60);    // misaligned PCs behind in-flight fetches
      knobs(100, 3, 3, 30, 20, 10);  run(300);   // flushes with requests outstanding
      do_reset();
      knobs(70, 1, 4, 60, 8, 8);     run(3000);
      knobs(90, 1, 6, 80, 25, 5);    run(2000);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
